// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: loads two WIDTH-bit operands, adds one bit pair per cycle.
// Optional SERIAL_ADD_OVF_EN adds a registered signed-overflow output (ovf).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_init,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sh_a_q, sh_a_d;
    logic [WIDTH-1:0]  sh_b_q, sh_b_d;
    logic [WIDTH-1:0]  sh_sum_q, sh_sum_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              carry_out_q, carry_out_d;
    logic              fa_sum, fa_cout;
`ifdef SERIAL_ADD_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    // Full adder cell on the current LSB pair and the registered carry.
    always_comb begin
        fa_sum  = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
        fa_cout = (sh_a_q[0] & sh_b_q[0]) | (carry_q & (sh_a_q[0] ^ sh_b_q[0]));
    end

    always_comb begin
        state_d     = state_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        sh_sum_d    = sh_sum_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d       = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sh_a_d  = op_a;
                    sh_b_d  = op_b;
                    carry_d = cin_init;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sh_sum_d = {fa_sum, sh_sum_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                sh_a_d   = sh_a_q >> 1;
                sh_b_d   = sh_b_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    result_d    = {fa_sum, sh_sum_q[WIDTH-1:1]};
                    carry_out_d = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on this final bit.
                    ovf_d       = carry_q ^ fa_cout;
`endif
                    cnt_d       = '0;
                    state_d     = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            sh_sum_q    <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            sh_sum_q    <= sh_sum_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign result    = result_q;
    assign carry_out = carry_out_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
